rd_tracker: RTL and testbench

Parametrised running-disparity tracker and codeword selector for the TX PCS 8b/10b encoder. It accepts `LANES` symbols per clock, each presented as a precomputed RD− and RD+ 10-bit codeword. It chains the running disparity (RD) through the lanes in order, selects the correct codeword per lane, and registers the result for the serializer. Unlike a plain toggle, RD flips only on unbalanced codewords. The block also supports a forced-RD load, per-lane disparity-error detection and a saturating error counter.

---
 rtl/rd_tracker_pkg.sv | 18 +
 rtl/rd_lane_step.sv | 34 +++
 rtl/rd_tracker.sv | 108 ++++++++++
 tb/tb_rd_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_tracker_pkg.sv
// Shared PCS definitions for the 8b/10b running-disparity tracker:
// RD encodings, codeword width and a codeword popcount helper.
package rd_tracker_pkg;

   localparam int   CW_W   = 10;
   localparam logic RD_NEG = 1'b0;
   localparam logic RD_POS = 1'b1;

   function automatic logic [3:0] popcount10(input logic [CW_W-1:0] cw);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < CW_W; i++) begin
         n = n + {3'b000, cw[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/rd_lane_step.sv
// One lane of the RD chain: picks the codeword for the incoming RD, then
// derives the outgoing RD and flags codewords whose weight violates RD.
module rd_lane_step
   import rd_tracker_pkg::*;
(
   input  logic [CW_W-1:0] cw_neg_i,
   input  logic [CW_W-1:0] cw_pos_i,
   input  logic            rd_in_i,
   output logic [CW_W-1:0] cw_o,
   output logic            rd_out_o,
   output logic            err_o
);

   logic [3:0] ones;

   always_comb begin
      cw_o     = (rd_in_i == RD_POS) ? cw_pos_i : cw_neg_i;
      ones     = popcount10(cw_o);
      err_o    = 1'b0;
      rd_out_o = rd_in_i;
      if (ones == 4'd5) begin
         rd_out_o = rd_in_i;
      end else if (ones == 4'd6 && rd_in_i == RD_NEG) begin
         rd_out_o = RD_POS;
      end else if (ones == 4'd4 && rd_in_i == RD_POS) begin
         rd_out_o = RD_NEG;
      end else begin
         // Illegal weight for this RD: resync RD to the codeword's own sign.
         err_o    = 1'b1;
         rd_out_o = (ones > 4'd5) ? RD_POS : RD_NEG;
      end
   end

endmodule

// File: rtl/rd_tracker.sv
// Multi-lane running-disparity tracker and codeword selector for the TX PCS.
// Chains RD through the lanes combinationally and registers the result.
module rd_tracker
   import rd_tracker_pkg::*;
#(
   parameter int   LANES   = 1,
   parameter logic RD_INIT = 1'b0,
   parameter int   CNT_W   = 8
) (
   input  logic                  Bit_Rate_10,
   input  logic                  Rst,
   input  logic                  enable,
   input  logic                  in_valid,
   input  logic [LANES*CW_W-1:0] data_neg,
   input  logic [LANES*CW_W-1:0] data_pos,
   input  logic                  force_rd_en,
   input  logic                  force_rd_val,
   input  logic                  err_clr,
   output logic                  out_valid,
   output logic [LANES*CW_W-1:0] Data_10,
   output logic                  rd_out,
   output logic [LANES-1:0]      disp_err,
   output logic [CNT_W-1:0]      err_count
);

   localparam int NE_W  = $clog2(LANES + 1);
   localparam int SUM_W = CNT_W + 3;
   localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

   logic [LANES:0]                 rd_chain;
   logic [LANES-1:0][CW_W-1:0]     sel_cw;
   logic [LANES-1:0]               lane_err;

   logic                  rd_q,   rd_d;
   logic                  vld_q,  vld_d;
   logic [LANES*CW_W-1:0] data_q, data_d;
   logic [LANES-1:0]      err_q,  err_d;
   logic [CNT_W-1:0]      cnt_q,  cnt_d;

   logic [NE_W-1:0]  new_errs;
   logic [SUM_W-1:0] cnt_sum;

   assign rd_chain[0] = force_rd_en ? force_rd_val : rd_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      rd_lane_step u_step (
         .cw_neg_i (data_neg[g*CW_W +: CW_W]),
         .cw_pos_i (data_pos[g*CW_W +: CW_W]),
         .rd_in_i  (rd_chain[g]),
         .cw_o     (sel_cw[g]),
         .rd_out_o (rd_chain[g+1]),
         .err_o    (lane_err[g])
      );
   end

   always_comb begin
      new_errs = '0;
      if (in_valid) begin
         for (int i = 0; i < LANES; i++) begin
            new_errs = new_errs + NE_W'(lane_err[i]);
         end
      end
      // Clear wins over the old value but still counts this cycle's errors.
      cnt_sum = (err_clr ? '0 : {3'b000, cnt_q}) + SUM_W'(new_errs);
      cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
   end

   always_comb begin
      rd_d   = rd_q;
      vld_d  = vld_q;
      data_d = data_q;
      err_d  = err_q;
      if (enable) begin
         vld_d = in_valid;
         err_d = '0;
         if (in_valid) begin
            rd_d   = rd_chain[LANES];
            data_d = sel_cw;
            err_d  = lane_err;
         end
      end
   end

   always_ff @(posedge Bit_Rate_10 or posedge Rst) begin
      if (Rst) begin
         rd_q   <= RD_INIT;
         vld_q  <= 1'b0;
         data_q <= '0;
         err_q  <= '0;
         cnt_q  <= '0;
      end else begin
         rd_q   <= rd_d;
         vld_q  <= vld_d;
         data_q <= data_d;
         err_q  <= err_d;
         if (enable) begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign out_valid = vld_q;
   assign Data_10   = data_q;
   assign rd_out    = rd_q;
   assign disp_err  = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_rd_tracker.sv
// Bench for rd_tracker: a 1-lane and a 4-lane instance share control inputs
// and are checked against a word-level reference model of the RD rules.
module tb_rd_tracker;

   logic clk = 1'b0;
   logic rst, en, iv, fen, fval, eclr;
   logic [9:0]  n1, p1;
   logic [39:0] n4, p4;

   logic        ov1, ro1;
   logic [9:0]  d1;
   logic [0:0]  de1;
   logic [7:0]  ec1;
   logic        ov4, ro4;
   logic [39:0] d4;
   logic [3:0]  de4;
   logic [7:0]  ec4;

   int checks = 0;
   int errors = 0;

   logic        m1_rd, m1_vld, m4_rd, m4_vld;
   logic [39:0] m1_data, m4_data;
   logic [3:0]  m1_err, m4_err;
   int          m1_cnt, m4_cnt;

   always #5 clk = ~clk;

   rd_tracker #(.LANES(1), .RD_INIT(1'b0), .CNT_W(8)) dut1 (
      .Bit_Rate_10(clk), .Rst(rst), .enable(en), .in_valid(iv),
      .data_neg(n1), .data_pos(p1), .force_rd_en(fen), .force_rd_val(fval),
      .err_clr(eclr), .out_valid(ov1), .Data_10(d1), .rd_out(ro1),
      .disp_err(de1), .err_count(ec1));

   rd_tracker #(.LANES(4), .RD_INIT(1'b0), .CNT_W(8)) dut4 (
      .Bit_Rate_10(clk), .Rst(rst), .enable(en), .in_valid(iv),
      .data_neg(n4), .data_pos(p4), .force_rd_en(fen), .force_rd_val(fval),
      .err_clr(eclr), .out_valid(ov4), .Data_10(d4), .rd_out(ro4),
      .disp_err(de4), .err_count(ec4));

   // Walks the lanes in order applying the disparity rules to a whole word.
   function automatic void ref_word(input int n, input logic rd_in,
                                    input logic [39:0] neg, input logic [39:0] pos,
                                    output logic [39:0] sel, output logic [3:0] err,
                                    output logic rd_end);
      logic rd;
      logic [9:0] s;
      int o;
      rd = rd_in; sel = '0; err = '0;
      for (int i = 0; i < n; i++) begin
         s = rd ? pos[10*i +: 10] : neg[10*i +: 10];
         sel[10*i +: 10] = s;
         o = $countones(s);
         if (o == 5) begin end
         else if (o == 6 && !rd) rd = 1'b1;
         else if (o == 4 && rd)  rd = 1'b0;
         else begin err[i] = 1'b1; rd = (o > 5); end
      end
      rd_end = rd;
   endfunction

   task automatic model_reset();
      m1_rd = 0; m1_vld = 0; m1_data = '0; m1_err = '0; m1_cnt = 0;
      m4_rd = 0; m4_vld = 0; m4_data = '0; m4_err = '0; m4_cnt = 0;
   endtask

   // Advance model with the inputs currently driven, then step one clock.
   task automatic tick();
      logic [39:0] s;
      logic [3:0]  e;
      logic        r;
      int          ne;
      if (!rst && en) begin
         ne = 0; m1_err = '0;
         if (iv) begin
            ref_word(1, fen ? fval : m1_rd, {30'b0, n1}, {30'b0, p1}, s, e, r);
            m1_data = s; m1_err = e; m1_rd = r; ne = $countones(e);
         end
         m1_vld = iv;
         m1_cnt = eclr ? ne : m1_cnt + ne;
         if (m1_cnt > 255) m1_cnt = 255;
         ne = 0; m4_err = '0;
         if (iv) begin
            ref_word(4, fen ? fval : m4_rd, n4, p4, s, e, r);
            m4_data = s; m4_err = e; m4_rd = r; ne = $countones(e);
         end
         m4_vld = iv;
         m4_cnt = eclr ? ne : m4_cnt + ne;
         if (m4_cnt > 255) m4_cnt = 255;
      end
      @(posedge clk); #1;
      if (rst) model_reset();
   endtask

   task automatic do_reset();
      rst = 1'b1; iv = 1'b0; fen = 1'b0; eclr = 1'b0;
      #1; model_reset();
      @(negedge clk); rst = 1'b0;
   endtask

   function automatic logic [9:0] rnd_lane(input int k);
      case (k)
         0: return 10'h0FA;
         1: return 10'h305;
         2: return 10'h2AA;
         default: return 10'($urandom);
      endcase
   endfunction

   task automatic rand_data();
      int k;
      k = $urandom_range(0, 3);
      n1 = (k < 2) ? 10'h0FA : rnd_lane(k);
      p1 = (k < 2) ? 10'h305 : rnd_lane($urandom_range(2, 3));
      for (int i = 0; i < 4; i++) begin
         k = $urandom_range(0, 3);
         n4[10*i +: 10] = (k < 2) ? 10'h0FA : rnd_lane(k);
         p4[10*i +: 10] = (k < 2) ? 10'h305 : rnd_lane($urandom_range(2, 3));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; iv = 1'b0; fen = 1'b0; fval = 1'b0; eclr = 1'b0;
      n1 = '0; p1 = '0; n4 = '0; p4 = '0;
      #2; model_reset();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1: got %b want 0", ov1); end
      checks++; if (d1 !== 10'h0) begin errors++; $display("FAIL reset_d1: got %h want 000", d1); end
      checks++; if (ro1 !== 1'b0) begin errors++; $display("FAIL reset_rd1: got %b want 0", ro1); end
      checks++; if (de1 !== 1'b0) begin errors++; $display("FAIL reset_de1: got %b want 0", de1); end
      checks++; if (ec1 !== 8'd0) begin errors++; $display("FAIL reset_ec1: got %0d want 0", ec1); end
      checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_ov4: got %b want 0", ov4); end
      checks++; if (d4 !== 40'h0) begin errors++; $display("FAIL reset_d4: got %h want 0", d4); end
      checks++; if (ro4 !== 1'b0) begin errors++; $display("FAIL reset_rd4: got %b want 0", ro4); end
      checks++; if (de4 !== 4'h0) begin errors++; $display("FAIL reset_de4: got %h want 0", de4); end
      checks++; if (ec4 !== 8'd0) begin errors++; $display("FAIL reset_ec4: got %0d want 0", ec4); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_k285();
      logic [9:0] ed [3];
      logic       er [3];
      ed = '{10'h0FA, 10'h305, 10'h0FA};
      er = '{1'b1, 1'b0, 1'b1};
      do_reset();
      en = 1'b1; iv = 1'b1; n1 = 10'h0FA; p1 = 10'h305;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (d1 !== ed[i]) begin errors++; $display("FAIL k285_data[%0d]: got %h want %h", i, d1, ed[i]); end
         checks++; if (ro1 !== er[i]) begin errors++; $display("FAIL k285_rd[%0d]: got %b want %b", i, ro1, er[i]); end
         checks++; if (de1 !== 1'b0) begin errors++; $display("FAIL k285_err[%0d]: got %b want 0", i, de1); end
         checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL k285_vld[%0d]: got %b want 1", i, ov1); end
      end
   endtask

   task automatic test_balanced();
      do_reset();
      iv = 1'b1; n1 = 10'h2AA; p1 = 10'h2AA;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (d1 !== 10'h2AA) begin errors++; $display("FAIL bal_data[%0d]: got %h want 2aa", i, d1); end
         checks++; if (ro1 !== 1'b0) begin errors++; $display("FAIL bal_rd[%0d]: got %b want 0", i, ro1); end
      end
   endtask

   task automatic test_lanes4();
      logic [39:0] exp_d;
      do_reset();
      iv = 1'b1;
      n4 = {10'h0FA, 10'h0FA, 10'h2AA, 10'h0FA};
      p4 = {10'h305, 10'h305, 10'h2AA, 10'h305};
      exp_d = {10'h0FA, 10'h305, 10'h2AA, 10'h0FA};
      tick();
      checks++; if (d4 !== exp_d) begin errors++; $display("FAIL l4_data: got %h want %h", d4, exp_d); end
      checks++; if (ro4 !== 1'b1) begin errors++; $display("FAIL l4_rd: got %b want 1", ro4); end
      checks++; if (de4 !== 4'h0) begin errors++; $display("FAIL l4_err: got %h want 0", de4); end
      checks++; if (d4 !== m4_data) begin errors++; $display("FAIL l4_model: got %h want %h", d4, m4_data); end
   endtask

   task automatic test_err_sat();
      do_reset();
      iv = 1'b1; n1 = 10'h3FF; p1 = 10'h3FF;
      for (int k = 1; k <= 256; k++) begin
         rand_data(); n1 = 10'h3FF; p1 = 10'h3FF;
         tick();
         if (k == 1) begin
            checks++; if (de1 !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", de1); end
            checks++; if (ro1 !== 1'b1) begin errors++; $display("FAIL err_rd: got %b want 1", ro1); end
         end
         if (k == 255 || k == 256) begin
            checks++; if (ec1 !== 8'd255) begin errors++; $display("FAIL err_sat[%0d]: got %0d want 255", k, ec1); end
            checks++; if (ec4 !== 8'(m4_cnt)) begin errors++; $display("FAIL err_sat4[%0d]: got %0d want %0d", k, ec4, m4_cnt); end
         end
      end
      eclr = 1'b1;
      tick();
      checks++; if (ec1 !== 8'd1) begin errors++; $display("FAIL clr_err: got %0d want 1", ec1); end
      iv = 1'b0;
      tick();
      checks++; if (ec1 !== 8'd0) begin errors++; $display("FAIL clr_idle: got %0d want 0", ec1); end
      checks++; if (ov1 !== 1'b0 || de1 !== 1'b0) begin errors++; $display("FAIL idle_vld: got ov=%b de=%b want 0 0", ov1, de1); end
      checks++; if (d1 !== 10'h3FF) begin errors++; $display("FAIL idle_hold: got %h want 3ff", d1); end
      eclr = 1'b0;
   endtask

   task automatic test_force();
      do_reset();
      iv = 1'b1; fen = 1'b1; fval = 1'b1; n1 = 10'h0FA; p1 = 10'h305;
      tick();
      checks++; if (d1 !== 10'h305) begin errors++; $display("FAIL force_data: got %h want 305", d1); end
      checks++; if (ro1 !== 1'b0) begin errors++; $display("FAIL force_rd: got %b want 0", ro1); end
      iv = 1'b0;
      tick();
      checks++; if (ro1 !== 1'b0 || d1 !== 10'h305) begin errors++; $display("FAIL force_idle: got rd=%b d=%h want 0 305", ro1, d1); end
      fen = 1'b0;
   endtask

   task automatic test_stall();
      iv = 1'b1; rand_data();
      tick();
      en = 1'b0; eclr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_data(); fen = 1'($urandom); fval = 1'($urandom);
         tick();
         checks++; if (ov1 !== m1_vld || d1 !== m1_data[9:0] || ro1 !== m1_rd || ec1 !== 8'(m1_cnt))
            begin errors++; $display("FAIL stall1[%0d]: got %b %h %b %0d want %b %h %b %0d", i, ov1, d1, ro1, ec1, m1_vld, m1_data[9:0], m1_rd, m1_cnt); end
         checks++; if (ov4 !== m4_vld || d4 !== m4_data || de4 !== m4_err || ec4 !== 8'(m4_cnt))
            begin errors++; $display("FAIL stall4[%0d]: got %b %h %h %0d want %b %h %h %0d", i, ov4, d4, de4, ec4, m4_vld, m4_data, m4_err, m4_cnt); end
      end
      en = 1'b1; eclr = 1'b0; fen = 1'b0;
   endtask

   task automatic test_reset_midstream();
      iv = 1'b1; n1 = 10'h0FA; p1 = 10'h305; rand_data(); n1 = 10'h0FA; p1 = 10'h305;
      tick();
      checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", ov1); end
      rst = 1'b1; #1; model_reset();
      checks++; if (ov1 !== 1'b0 || d1 !== 10'h0 || ro1 !== 1'b0 || ec1 !== 8'd0)
         begin errors++; $display("FAIL mid_rst1: got %b %h %b %0d want 0 000 0 0", ov1, d1, ro1, ec1); end
      checks++; if (ov4 !== 1'b0 || d4 !== 40'h0 || de4 !== 4'h0)
         begin errors++; $display("FAIL mid_rst4: got %b %h %h want 0 0 0", ov4, d4, de4); end
      tick();
      checks++; if (ov4 !== 1'b0 || d4 !== 40'h0) begin errors++; $display("FAIL mid_hold: got %b %h want 0 0", ov4, d4); end
      @(negedge clk); rst = 1'b0; iv = 1'b0;
      tick();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL mid_post: got %b want 0", ov1); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         en   = ($urandom_range(0, 7) != 0);
         iv   = ($urandom_range(0, 3) != 0);
         fen  = ($urandom_range(0, 7) == 0);
         fval = 1'($urandom);
         eclr = ($urandom_range(0, 15) == 0);
         rand_data();
         tick();
         checks++; if (ov1 !== m1_vld || d1 !== m1_data[9:0] || ro1 !== m1_rd || de1 !== m1_err[0] || ec1 !== 8'(m1_cnt))
            begin errors++; $display("FAIL rnd1[%0d]: got %b %h %b %b %0d want %b %h %b %b %0d", c, ov1, d1, ro1, de1, ec1, m1_vld, m1_data[9:0], m1_rd, m1_err[0], m1_cnt); end
         checks++; if (ov4 !== m4_vld || d4 !== m4_data || ro4 !== m4_rd || de4 !== m4_err || ec4 !== 8'(m4_cnt))
            begin errors++; $display("FAIL rnd4[%0d]: got %b %h %b %h %0d want %b %h %b %h %0d", c, ov4, d4, ro4, de4, ec4, m4_vld, m4_data, m4_rd, m4_err, m4_cnt); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_k285();
      test_balanced();
      test_lanes4();
      test_err_sat();
      test_force();
      test_stall();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
